// File: rtl/br_pred_update_ctrl.sv
// br_pred_update_ctrl
//   Update scheduler for the branch-direction counter table. Resolved
//   branches from every CDB lane are queued and drained into the single
//   table write port one per cycle, oldest first. After reset the block
//   sweeps every table entry to its init value before accepting updates.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset
//   cdb        : CDB lanes (instr_is_br, br_taken, instr_pc used)
//   tbl_we     : table write strobe
//   tbl_idx    : table entry written this cycle
//   tbl_taken  : 1 = increment, 0 = decrement (ignored when tbl_init=1)
//   tbl_init   : write the weakly-not-taken init value
//   init_done  : initialization sweep complete
//   q_count    : update queue occupancy
//   drop_cnt   : saturating count of updates dropped on queue overflow

package br_pred_pkg;
  typedef struct packed {
    logic        instr_is_br;
    logic        br_taken;
    logic [31:0] instr_pc;
  } cdb_t;
endpackage

module br_pred_update_ctrl
  import br_pred_pkg::*;
#(
  parameter int NUM_CDB     = 2,
  parameter int NUM_BR_PRED = 16,
  parameter int QUEUE_DEPTH = 4,
  localparam int NUM_BR_PRED_BITS = $clog2(NUM_BR_PRED),
  localparam int CW               = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  cdb_t                        cdb [NUM_CDB],
  output logic                        tbl_we,
  output logic [NUM_BR_PRED_BITS-1:0] tbl_idx,
  output logic                        tbl_taken,
  output logic                        tbl_init,
  output logic                        init_done,
  output logic [CW-1:0]               q_count,
  output logic [15:0]                 drop_cnt
);

  localparam int IW = NUM_BR_PRED_BITS;
  localparam int PW = $clog2(QUEUE_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   sweep_q, sweep_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     drop_q, drop_d;

  // Queue payload is data only: never reset, validity comes from count_q.
  logic [IW-1:0]   mem_idx_q [QUEUE_DEPTH];
  logic            mem_tkn_q [QUEUE_DEPTH];

  logic [CW-1:0]   free_slots;
  logic [CW-1:0]   n_acc;
  logic [CW-1:0]   n_drop;
  logic            lane_acc  [NUM_CDB];
  logic [PW-1:0]   lane_slot [NUM_CDB];
  logic            pop;

  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                             input logic [CW-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Only the index bits of the PC are consumed.
  logic [NUM_CDB-1:0] unused_pc_bits;
  for (genvar g = 0; g < NUM_CDB; g++) begin : g_unused
    assign unused_pc_bits[g] = ^{cdb[g].instr_pc[1:0], cdb[g].instr_pc[31:2+IW]};
  end

  // Free slots are taken from the registered count: a same-cycle pop
  // does not make room for an extra enqueue.
  assign free_slots = CW'(QUEUE_DEPTH) - count_q;
  assign pop        = (state_q == S_RUN) && (count_q != '0);

  // Lower lanes are older, so they claim free slots first.
  always_comb begin
    n_acc  = '0;
    n_drop = '0;
    for (int i = 0; i < NUM_CDB; i++) begin
      lane_acc[i]  = 1'b0;
      lane_slot[i] = '0;
      if ((state_q == S_RUN) && cdb[i].instr_is_br) begin
        if (n_acc < free_slots) begin
          lane_acc[i]  = 1'b1;
          lane_slot[i] = tail_q + n_acc[PW-1:0];
          n_acc        = n_acc + CW'(1);
        end else begin
          n_drop = n_drop + CW'(1);
        end
      end
    end
  end

  // Next-state / pointer logic
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + IW'(1);
        if (sweep_q == IW'(NUM_BR_PRED - 1)) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + n_acc[PW-1:0];
    count_d = count_q + n_acc - CW'(pop);
    drop_d  = sat_add16(drop_q, n_drop);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CDB; i++) begin
      if (lane_acc[i]) begin
        mem_idx_q[lane_slot[i]] <= cdb[i].instr_pc[2 +: IW];
        mem_tkn_q[lane_slot[i]] <= cdb[i].br_taken;
      end
    end
  end

  // Outputs are forced quiet while reset is held, independent of state.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_init  = 1'b0;
    tbl_idx   = '0;
    tbl_taken = 1'b0;
    init_done = 1'b0;
    if (!rst) begin
      case (state_q)
        S_INIT: begin
          tbl_we   = 1'b1;
          tbl_init = 1'b1;
          tbl_idx  = sweep_q;
        end
        S_RUN: begin
          init_done = 1'b1;
          if (count_q != '0) begin
            tbl_we    = 1'b1;
            tbl_idx   = mem_idx_q[head_q];
            tbl_taken = mem_tkn_q[head_q];
          end
        end
        default: ;
      endcase
    end
  end

  assign q_count  = count_q;
  assign drop_cnt = drop_q;

endmodule
